enc_repacker: RTL and testbench
===============================

ENC_REPACKER -- requirements
Module: enc_repacker

Interface
REQ-001 Parameter SYM_W, default EGF_ORDER, symbol width in bits.
REQ-002 Parameter IN_SYM, default ENC_SYM_NUM, input lanes per cycle.
REQ-003 Parameter OUT_SYM, default ENC_SYM_NUM, output lanes per word.
REQ-004 Parameter CAP, default 2*ENC_SYM_NUM, storage depth in symbols; CAP < IN_SYM+OUT_SYM SHALL fail elaboration.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  input beat offered.
REQ-008 in_ready  out  1  input beat acceptable; transfer = in_valid && in_ready.
REQ-009 in_count  in  $clog2(IN_SYM+1)  valid symbols in beat; lanes 0..in_count-1, lane 0 oldest.
REQ-010 in_data  in  IN_SYM x SYM_W  input symbols.
REQ-011 in_last  in  1  final symbol of codeword is in this beat (beat may carry 0 symbols).
REQ-012 out_valid  out  1  output word offered.
REQ-013 out_ready  in  1  consumer accepts; pop = out_valid && out_ready.
REQ-014 out_count  out  $clog2(OUT_SYM+1)  valid lanes in output word, lane 0 oldest.
REQ-015 out_data  out  OUT_SYM x SYM_W  output symbols; lanes >= out_count SHALL be zero.
REQ-016 out_last  out  1  word ends the codeword.
REQ-017 level  out  $clog2(CAP+1)  symbols currently stored.
REQ-018 err  out  1  sticky illegal-input flag.

Function
REQ-019 Storage SHALL be a symbol shift register, index 0 oldest; level counts occupied entries.
REQ-020 in_ready SHALL be 1 iff state==FIL and CAP-level >= IN_SYM (registered level only; no same-cycle pop credit).
REQ-021 Push SHALL write accepted symbols at indices level-pop_cnt .. level-pop_cnt+in_count-1.
REQ-022 Pop SHALL shift storage down by out_count; vacated entries SHALL be zeroed.
REQ-023 level_next SHALL equal level + push_cnt - pop_cnt; simultaneous push and pop legal in same cycle.
REQ-024 Latency: symbol accepted in cycle N SHALL be visible on out_data no earlier than and by cycle N+1 if ahead-of-queue allows.
REQ-025 out_data, out_count, out_valid, out_last SHALL be decoded combinationally from registered storage, level and state.
REQ-026 State FIL: out_valid = (level >= OUT_SYM); out_count = OUT_SYM; out_last = 0.
REQ-027 FIL -> DRN on accepted beat with in_last=1; in_ready SHALL stay 0 throughout DRN.
REQ-028 State DRN, level > OUT_SYM: out_valid=1, out_count=OUT_SYM, out_last=0.
REQ-029 State DRN, level <= OUT_SYM: out_valid=1, out_count=level, out_last=1, including level==0 (zero-length tail word).
REQ-030 DRN -> FIL on pop with out_last=1; in_ready may assert in following cycle.
REQ-031 in_count > IN_SYM on accepted beat SHALL be clamped to IN_SYM and SHALL set err; err cleared only by reset.
REQ-032 in_count == 0 accepted beat SHALL leave storage unchanged and still honour in_last.
REQ-033 Stable output: while out_valid && !out_ready, out_data/out_count/out_last SHALL not change.

Reset
REQ-034 rst_n low SHALL immediately force: storage all zero, level 0, state FIL, err 0, out_valid 0, out_last 0, out_count 0, in_ready 1.
REQ-035 Reset mid-codeword SHALL discard all stored symbols and pending last without producing an output word.

Verification (IN_SYM=4, OUT_SYM=3, CAP=8, SYM_W=8)
REQ-036 Push count 4 {01,02,03,04}, out_ready=1 -> next cycle out_valid=1, out_data={01,02,03}, out_count=3; after pop level=1.
REQ-037 out_ready=0, push two count-4 beats -> level=8, in_ready=0, third held beat not accepted, level stays 8.
REQ-038 Push {A1..A4} count 4 with in_last -> DRN, in_ready=0; words {A1,A2,A3} last=0, then {A4,00,00} count 1 last=1; then FIL, in_ready=1.
REQ-039 level=0, beat in_count=0, in_last=1 -> out_valid=1, out_count=0, out_last=1, out_data all zero.
REQ-040 Beat in_count=7 -> err=1, exactly 4 symbols stored; err stays 1 until rst_n low.
REQ-041 level=5 mid-DRN, pulse rst_n low between clock edges -> outputs reset values at once, no stale word after release.

Source files
------------

// File: rtl/enc_repacker.sv
// enc_repacker: regroups variable-count input beats of encoder symbols into
// fixed-width output words. Symbols live in a shift register (index 0 oldest).
// FIL accumulates full words. An accepted in_last moves the block to DRN,
// which empties the storage and ends with a tail word flagged out_last.
module enc_repacker #(
  parameter int EGF_ORDER   = 8,
  parameter int ENC_SYM_NUM = 4,
  parameter int SYM_W       = EGF_ORDER,
  parameter int IN_SYM      = ENC_SYM_NUM,
  parameter int OUT_SYM     = ENC_SYM_NUM,
  parameter int CAP         = 2 * ENC_SYM_NUM
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [$clog2(IN_SYM+1)-1:0]          in_count,
  input  logic [IN_SYM-1:0][SYM_W-1:0]         in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(OUT_SYM+1)-1:0]         out_count,
  output logic [OUT_SYM-1:0][SYM_W-1:0]        out_data,
  output logic                                 out_last,
  output logic [$clog2(CAP+1)-1:0]             level,
  output logic                                 err
);

  localparam int OCW = $clog2(OUT_SYM + 1);
  localparam int LW  = $clog2(CAP + 1);

  // A full input beat and a full output word must both fit in the storage.
  if (CAP < IN_SYM + OUT_SYM) begin : g_bad_cap
    $error("enc_repacker: CAP must be at least IN_SYM+OUT_SYM");
  end

  typedef enum logic {
    FIL = 1'b0,
    DRN = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [CAP-1:0][SYM_W-1:0]     store_q, store_d;
  logic [LW-1:0]                 level_q, level_d;
  logic                          err_q, err_d;

  logic                          outValid;
  logic                          outLast;
  int                            outCnt;
  logic                          accept;
  logic                          pop;
  int                            pushCnt;
  int                            popCnt;
  int                            pushBase;
  logic                          clampHit;
  logic [IN_SYM*SYM_W-1:0]       inMask;
  logic [CAP*SYM_W-1:0]          shiftedStore;
  logic [CAP*SYM_W-1:0]          pushVec;
  logic [OUT_SYM*SYM_W-1:0]      outMask;

  // Output word decode: comes only from registered state and level, so the
  // offered word stays put while the consumer stalls.
  always_comb begin
    outValid = 1'b0;
    outLast  = 1'b0;
    outCnt   = 0;
    if (state_q == FIL) begin
      if (int'(level_q) >= OUT_SYM) begin
        outValid = 1'b1;
        outCnt   = OUT_SYM;
      end
    end else begin
      outValid = 1'b1;
      if (int'(level_q) > OUT_SYM) begin
        outCnt = OUT_SYM;
      end else begin
        outCnt  = int'(level_q);
        outLast = 1'b1;
      end
    end
  end

  // Lanes at or beyond out_count are forced to zero.
  always_comb begin
    outMask  = ~({(OUT_SYM*SYM_W){1'b1}} << (outCnt * SYM_W));
    out_data = store_q[OUT_SYM-1:0] & outMask;
  end

  assign out_valid = outValid;
  assign out_last  = outLast;
  assign out_count = OCW'(outCnt);
  assign level     = level_q;
  assign err       = err_q;

  // Input acceptance uses the registered level only, with no credit for a pop
  // in the same cycle; that keeps in_ready independent of out_ready.
  assign in_ready = (state_q == FIL) && ((CAP - int'(level_q)) >= IN_SYM);
  assign accept   = in_valid && in_ready;
  assign pop      = outValid && out_ready;

  // Transfer sizes for this cycle; oversize counts are clamped and flagged.
  always_comb begin
    pushCnt  = 0;
    popCnt   = 0;
    clampHit = 1'b0;
    if (accept) begin
      if (int'(in_count) > IN_SYM) begin
        pushCnt  = IN_SYM;
        clampHit = 1'b1;
      end else begin
        pushCnt = int'(in_count);
      end
    end
    if (pop) begin
      popCnt = outCnt;
    end
    pushBase = int'(level_q) - popCnt;
  end

  // Storage update: pop shifts the whole register down with zero fill, then
  // accepted lanes land right after the surviving entries. Entries above the
  // level are always zero, so an OR merges the two.
  always_comb begin
    shiftedStore = store_q >> (popCnt * SYM_W);
    inMask       = ~({(IN_SYM*SYM_W){1'b1}} << (pushCnt * SYM_W));
    pushVec      = {{((CAP-IN_SYM)*SYM_W){1'b0}}, (in_data & inMask)} << (pushBase * SYM_W);
    store_d      = shiftedStore | pushVec;
    level_d      = LW'(int'(level_q) + pushCnt - popCnt);
    err_d        = err_q | clampHit;
  end

  // Next-state logic: FIL leaves on an accepted last beat (even an empty one),
  // DRN returns once the word carrying out_last has been consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FIL: begin
        if (accept && in_last) begin
          state_d = DRN;
        end
      end
      DRN: begin
        if (pop && outLast) begin
          state_d = FIL;
        end
      end
      default: state_d = FIL;
    endcase
  end

  // State registers; reset discards stored symbols and any pending codeword end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIL;
      store_q <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_enc_repacker.sv
// Testbench for enc_repacker with IN_SYM=4, OUT_SYM=3, CAP=8, SYM_W=8.
// Directed table vectors and hand sequences come first. A randomized run then
// follows, checked against a queue-based model of the repacking rules.
module tb_enc_repacker;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_count;
  logic [3:0][7:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_count;
  logic [2:0][7:0] out_data;
  logic            out_last;
  logic [3:0]      level;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Reference model state: stored symbols oldest first, pending codeword end, error flag.
  logic [7:0] mq[$];
  bit         mDrain;
  bit         mErr;

  typedef struct {
    bit           inValid;
    int           inCount;
    logic [31:0]  inData;
    bit           inLast;
    bit           outReady;
    bit           expValid;
    int           expCount;
    bit           expLast;
    logic [23:0]  expData;
    int           expLevel;
    bit           expReady;
  } vec_t;

  vec_t tbl[17];

  enc_repacker #(
    .SYM_W   (8),
    .IN_SYM  (4),
    .OUT_SYM (3),
    .CAP     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .err       (err)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // One counted comparison; reports the failure and continues.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkRow(bit v, int c, logic [31:0] d, bit l, bit ordy,
                                 bit ev, int ec, bit el, logic [23:0] ed, int lvl, bit rdy);
    vec_t r;
    r.inValid = v; r.inCount = c; r.inData = d; r.inLast = l; r.outReady = ordy;
    r.expValid = ev; r.expCount = ec; r.expLast = el; r.expData = ed;
    r.expLevel = lvl; r.expReady = rdy;
    return r;
  endfunction

  // Idle the inputs.
  task automatic idleInputs();
    in_valid  = 1'b0;
    in_count  = 3'd0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  // Reset the DUT and the model, checking the reset values while rst_n is low.
  task automatic resetDut();
    @(negedge clk);
    idleInputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mDrain = 1'b0;
    mErr   = 1'b0;
  endtask

  // Model view of the offered word, derived from the queue and the drain flag.
  function automatic void modelOut(output bit v, output int c, output bit l);
    v = 1'b0; c = 0; l = 1'b0;
    if (!mDrain) begin
      if (mq.size() >= 3) begin v = 1'b1; c = 3; end
    end else begin
      v = 1'b1;
      if (mq.size() > 3) c = 3;
      else begin c = mq.size(); l = 1'b1; end
    end
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    bit v; int c; bit l;
    logic [2:0][7:0] ed;
    modelOut(v, c, l);
    chk("in_ready", 32'(in_ready), 32'(!mDrain && (8 - mq.size() >= 4)));
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("level", 32'(level), 32'(mq.size()));
    chk("err", 32'(err), 32'(mErr));
    if (v) begin
      ed = '0;
      for (int j = 0; j < c; j++) ed[j] = mq[j];
      chk("out_count", 32'(out_count), 32'(c));
      chk("out_last", 32'(out_last), 32'(l));
      chk("out_data", 32'(out_data), 32'(ed));
    end
  endtask

  // Draw one random cycle of input stimulus.
  task automatic applyStimulus();
    in_valid  = ($urandom_range(0, 9) < 7);
    in_count  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    in_data   = $urandom;
    in_last   = ($urandom_range(0, 5) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Advance the model by the transfers the current inputs cause at the next edge.
  task automatic modelStep();
    bit v; int c; bit l; bit rdy; int n;
    modelOut(v, c, l);
    rdy = !mDrain && (8 - mq.size() >= 4);
    if (v && out_ready) begin
      repeat (c) void'(mq.pop_front());
      if (l) mDrain = 1'b0;
    end
    if (in_valid && rdy) begin
      n = (int'(in_count) > 4) ? 4 : int'(in_count);
      if (int'(in_count) > 4) mErr = 1'b1;
      for (int j = 0; j < n; j++) mq.push_back(in_data[j]);
      if (in_last) mDrain = 1'b1;
    end
  endtask

  // Main sequence: directed table, hand-written corner cases, then the random run.
  initial begin
    idleInputs();
    rst_n = 1'b0;
    mDrain = 1'b0;
    mErr   = 1'b0;

    tbl[0]  = mkRow(1, 4, 32'h04030201, 0, 1,  1, 3, 0, 24'h030201, 4, 1);
    tbl[1]  = mkRow(0, 0, 32'h0,        0, 1,  0, 0, 0, 24'h0,      1, 1);
    tbl[2]  = mkRow(1, 0, 32'h0,        1, 0,  1, 1, 1, 24'h000004, 1, 0);
    tbl[3]  = mkRow(1, 4, 32'h44332211, 0, 1,  0, 0, 0, 24'h0,      0, 1);
    tbl[4]  = mkRow(1, 0, 32'h0,        1, 0,  1, 0, 1, 24'h0,      0, 0);
    tbl[5]  = mkRow(0, 0, 32'h0,        0, 0,  1, 0, 1, 24'h0,      0, 0);
    tbl[6]  = mkRow(0, 0, 32'h0,        0, 1,  0, 0, 0, 24'h0,      0, 1);
    tbl[7]  = mkRow(1, 4, 32'h14131211, 0, 0,  1, 3, 0, 24'h131211, 4, 1);
    tbl[8]  = mkRow(1, 4, 32'h18171615, 0, 0,  1, 3, 0, 24'h131211, 8, 0);
    tbl[9]  = mkRow(1, 4, 32'h1C1B1A19, 0, 0,  1, 3, 0, 24'h131211, 8, 0);
    tbl[10] = mkRow(0, 0, 32'h0,        0, 1,  1, 3, 0, 24'h161514, 5, 0);
    tbl[11] = mkRow(0, 0, 32'h0,        0, 1,  0, 0, 0, 24'h0,      2, 1);
    tbl[12] = mkRow(1, 0, 32'h0,        1, 0,  1, 2, 1, 24'h001817, 2, 0);
    tbl[13] = mkRow(0, 0, 32'h0,        0, 1,  0, 0, 0, 24'h0,      0, 1);
    tbl[14] = mkRow(1, 4, 32'hA4A3A2A1, 1, 0,  1, 3, 0, 24'hA3A2A1, 4, 0);
    tbl[15] = mkRow(0, 0, 32'h0,        0, 1,  1, 1, 1, 24'h0000A4, 1, 0);
    tbl[16] = mkRow(0, 0, 32'h0,        0, 1,  0, 0, 0, 24'h0,      0, 1);

    resetDut();

    // Directed vectors: drive on the falling edge, check after the next rising edge.
    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].inValid;
      in_count  = 3'(tbl[i].inCount);
      in_data   = tbl[i].inData;
      in_last   = tbl[i].inLast;
      out_ready = tbl[i].outReady;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].expValid));
      chk($sformatf("t%0d_level", i), 32'(level), 32'(tbl[i].expLevel));
      chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].expReady));
      if (tbl[i].expValid) begin
        chk($sformatf("t%0d_out_count", i), 32'(out_count), 32'(tbl[i].expCount));
        chk($sformatf("t%0d_out_last", i), 32'(out_last), 32'(tbl[i].expLast));
        chk($sformatf("t%0d_out_data", i), 32'(out_data), 32'(tbl[i].expData));
      end
    end
    idleInputs();

    // Oversize count: clamped to four symbols and err latched until reset.
    in_valid = 1'b1; in_count = 3'd7; in_data = 32'hB4B3B2B1;
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    chk("clamp_err", 32'(err), 32'd1);
    chk("clamp_level", 32'(level), 32'd4);
    chk("clamp_data", 32'(out_data), 32'h00B3B2B1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("clamp_level_after_pop", 32'(level), 32'd1);
    chk("clamp_err_sticky", 32'(err), 32'd1);
    resetDut();

    // Reset in the middle of a drain: outputs drop at once, nothing stale afterwards.
    in_valid = 1'b1; in_count = 3'd4; in_data = 32'hC4C3C2C1;
    @(posedge clk);
    @(negedge clk);
    in_count = 3'd1; in_data = 32'h000000C5; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    chk("mid_level", 32'(level), 32'd5);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_out_last", 32'(out_last), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_last", 32'(out_last), 32'd0);
    chk("async_out_count", 32'(out_count), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Randomized run against the model, with one reset in the middle.
    resetDut();
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) resetDut();
      checkOutput();
      applyStimulus();
      modelStep();
      @(negedge clk);
    end
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
